fixed_point_multiplier_booth_r4: RTL and testbench

Parametrised sequential signed fixed-point multiplier using radix-4 Booth recoding. It replaces the fixed 16-bit radix-2 multiplier in the ODE accelerator datapath. It takes configurable word and fraction widths and halves the iteration count. It produces a saturated, format-aligned result with overflow flag and a start/busy/finish handshake.

---
 rtl/fixed_point_pkg.sv | 32 +++
 rtl/booth_r4_encoder.sv | 28 ++
 rtl/fixed_point_multiplier_booth_r4.sv | 124 ++++++++++++
 tb/tb_fixed_point_multiplier_booth_r4.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point Booth radix-4 multiplier: default format,
// FSM state encoding, Booth digit encoding and saturation limit helpers.
package fixed_point_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_FRAC_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        NORM,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    // Limits are returned in 64 bits; callers keep the low w bits (w <= 64).
    function automatic logic [63:0] sat_pos_limit(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg_limit(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a digit select
// (zero, negate, magnitude two).
module booth_r4_encoder
    import fixed_point_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       zero,
    output logic       neg,
    output logic       two
);

    booth_digit_t digit;

    always_comb begin
        digit = ZERO;
        case (triplet)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        zero = (digit == ZERO);
        neg  = (digit == NEG1) || (digit == NEG2);
        two  = (digit == POS2) || (digit == NEG2);
    end

endmodule

// File: rtl/fixed_point_multiplier_booth_r4.sv
// Sequential signed fixed-point multiplier, radix-4 Booth, saturating output.
// Define MULT_ROUND_EN for round-half-up normalisation instead of truncation.
module fixed_point_multiplier_booth_r4
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             overflow_flag,
    output logic             busy,
    output logic             finish
);

    localparam int unsigned ITER  = WIDTH / 2;
    localparam int unsigned CNT_W = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
    localparam logic [63:0] SAT_POS64 = sat_pos_limit(WIDTH);
    localparam logic [63:0] SAT_NEG64 = sat_neg_limit(WIDTH);
    localparam logic [WIDTH-1:0] SAT_POS = SAT_POS64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_NEG = SAT_NEG64[WIDTH-1:0];
`ifdef MULT_ROUND_EN
    localparam logic [2*WIDTH:0] ROUND_K = (2*WIDTH+1)'(1) << (FRAC_BITS - 1);
`endif

    state_t state, state_next;

    logic signed [WIDTH-1:0] mcand;
    logic        [WIDTH-1:0] mplier;
    logic                    b_prev;
    logic signed [WIDTH+1:0] acc, mag, addend, sum;
    logic        [CNT_W-1:0] cnt;
    logic                    enc_zero, enc_neg, enc_two;

    logic signed [2*WIDTH:0] prod_ext, prod_adj, q;
    logic        [WIDTH+1:0] upper;
    logic        [WIDTH-1:0] norm_val;
    logic                    norm_ovf;

    booth_r4_encoder u_enc (
        .triplet ({mplier[1:0], b_prev}),
        .zero    (enc_zero),
        .neg     (enc_neg),
        .two     (enc_two)
    );

    always_comb begin
        mag    = enc_two ? {mcand[WIDTH-1], mcand, 1'b0} : {{2{mcand[WIDTH-1]}}, mcand};
        addend = enc_zero ? '0 : (enc_neg ? -mag : mag);
        sum    = acc + addend;
    end

    // One guard bit above the 2*WIDTH product keeps the rounding add from wrapping.
    always_comb begin
        prod_ext = {acc[WIDTH-1], acc[WIDTH-1:0], mplier};
`ifdef MULT_ROUND_EN
        prod_adj = prod_ext + ROUND_K;
`else
        prod_adj = prod_ext;
`endif
        q        = prod_adj >>> FRAC_BITS;
        upper    = q[2*WIDTH:WIDTH-1];
        norm_ovf = !((upper == '0) || (upper == '1));
        norm_val = norm_ovf ? (q[2*WIDTH] ? SAT_NEG : SAT_POS) : q[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand         <= '0;
            mplier        <= '0;
            b_prev        <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            result        <= '0;
            overflow_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= A;
                    mplier <= B;
                    b_prev <= 1'b0;
                    acc    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    acc    <= sum >>> 2;
                    mplier <= {sum[1:0], mplier[WIDTH-1:2]};
                    b_prev <= mplier[1];
                    cnt    <= cnt + CNT_W'(1);
                end
                NORM: begin
                    result        <= norm_val;
                    overflow_flag <= norm_ovf;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == CALC) || (state == NORM);
    assign finish = (state == DONE);

endmodule

// File: tb/tb_fixed_point_multiplier_booth_r4.sv
// Self-checking bench for fixed_point_multiplier_booth_r4 (16/10 and 24/12 instances).
module tb_fixed_point_multiplier_booth_r4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        start16 = 1'b0;
    logic [15:0] result16;
    logic        ovf16, busy16, fin16;
    logic [23:0] a24 = '0, b24 = '0;
    logic        start24 = 1'b0;
    logic [23:0] result24;
    logic        ovf24, busy24, fin24;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_point_multiplier_booth_r4 dut16 (
        .clk(clk), .reset(reset), .A(a16), .B(b16), .start(start16),
        .result(result16), .overflow_flag(ovf16), .busy(busy16), .finish(fin16)
    );

    fixed_point_multiplier_booth_r4 #(.WIDTH(24), .FRAC_BITS(12)) dut24 (
        .clk(clk), .reset(reset), .A(a24), .B(b24), .start(start24),
        .result(result24), .overflow_flag(ovf24), .busy(busy24), .finish(fin24)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: exact product, optional half-up rounding, floor shift, clamp.
    function automatic void ref_mul(input longint a, input longint b, input int w, input int f,
                                    output longint res, output bit ovf);
        longint p, qv, maxv, minv;
        p = a * b;
`ifdef MULT_ROUND_EN
        p = p + (longint'(1) <<< (f - 1));
`endif
        qv   = p >>> f;
        maxv = (longint'(1) <<< (w - 1)) - 1;
        minv = -(longint'(1) <<< (w - 1));
        if (qv > maxv)      begin res = maxv; ovf = 1'b1; end
        else if (qv < minv) begin res = minv; ovf = 1'b1; end
        else                begin res = qv;   ovf = 1'b0; end
    endfunction

    // Call with DUT idle, #1 after an edge; returns #1 after the edge finish appears.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit hold,
                         input bit toggle, input string name);
        longint er;
        bit eo;
        logic [15:0] exp_r;
        int n;
        bit done;
        ref_mul(longint'($signed(a)), longint'($signed(b)), 16, 10, er, eo);
        exp_r = er[15:0];
        a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk); #1;
        if (!hold) start16 = 1'b0;
        checks++;
        if (busy16 !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept got=%b want=1", name, busy16);
        end
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            if (toggle) begin a16 = 16'($urandom); b16 = 16'($urandom); end
            @(posedge clk); #1; n++;
            checks++;
            if (busy16 && fin16) begin
                failures++;
                $display("FAIL %s busy_finish_overlap cycle=%0d", name, n);
            end
            if (fin16) done = 1'b1;
        end
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL %s latency got=%0d want=9", name, n);
        end
        checks++;
        if (result16 !== exp_r || ovf16 !== eo) begin
            failures++;
            $display("FAIL %s result got=%h/%b want=%h/%b (A=%h B=%h)",
                     name, result16, ovf16, exp_r, eo, a, b);
        end
    endtask

    task automatic end16();
        start16 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result16 !== 16'h0 || ovf16 !== 1'b0 || busy16 !== 1'b0 || fin16 !== 1'b0) begin
            failures++;
            $display("FAIL reset16 got=%h/%b/%b/%b want=0000/0/0/0", result16, ovf16, busy16, fin16);
        end
        checks++;
        if (result24 !== 24'h0 || ovf24 !== 1'b0 || busy24 !== 1'b0 || fin24 !== 1'b0) begin
            failures++;
            $display("FAIL reset24 got=%h/%b/%b/%b want=000000/0/0/0", result24, ovf24, busy24, fin24);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hold_start();
        logic [15:0] exp_r = 16'h1800;
        run16(16'h0800, 16'h0C00, 1'b1, 1'b0, "basic_hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (fin16 !== 1'b1 || busy16 !== 1'b0 || result16 !== exp_r || ovf16 !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got=%b/%b/%h/%b want=1/0/%h/0",
                         i, fin16, busy16, result16, ovf16, exp_r);
            end
        end
        end16();
    endtask

    task automatic test_directed();
        logic [15:0] va [10] = '{16'h0800, 16'hFA00, 16'h5000, 16'h8000, 16'h8000,
                                 16'h0001, 16'h0400, 16'h7FFF, 16'h8000, 16'h0000};
        logic [15:0] vb [10] = '{16'h0C00, 16'h0800, 16'h1000, 16'h0800, 16'hFC00,
                                 16'h0200, 16'h0400, 16'h7FFF, 16'h8000, 16'h1234};
        for (int i = 0; i < 10; i++) begin
            run16(va[i], vb[i], 1'b0, 1'b0, $sformatf("directed%0d", i));
            end16();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run16(16'($urandom), 16'($urandom), i[0], i[1], $sformatf("random%0d", i));
            end16();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run16(16'($urandom), 16'($urandom), 1'b1, 1'b0, $sformatf("b2b%0d", i));
            start16 = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (fin16 !== 1'b0 || busy16 !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle%0d got fin=%b busy=%b want fin=0 busy=0", i, fin16, busy16);
            end
        end
    endtask

    task automatic test_reset_mid();
        a16 = 16'h1234; b16 = 16'h0567; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy16 !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_before got=%b want=1", busy16);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (result16 !== 16'h0 || ovf16 !== 1'b0 || busy16 !== 1'b0 || fin16 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h/%b/%b/%b want=0000/0/0/0", result16, ovf16, busy16, fin16);
        end
        #3 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy16 !== 1'b0 || fin16 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_discard got busy=%b fin=%b want 0/0", busy16, fin16);
        end
        run16(16'h0400, 16'h0400, 1'b0, 1'b1, "post_reset");
        end16();
    endtask

    task automatic test_wide();
        logic [23:0] va [3] = '{24'h002000, 24'hFFE800, 24'h400000};
        logic [23:0] vb [3] = '{24'h003000, 24'h002000, 24'h004000};
        for (int i = 0; i < 3; i++) begin
            longint er;
            bit eo;
            logic [23:0] exp_r;
            int n;
            ref_mul(longint'($signed(va[i])), longint'($signed(vb[i])), 24, 12, er, eo);
            exp_r = er[23:0];
            a24 = va[i]; b24 = vb[i]; start24 = 1'b1;
            @(posedge clk); #1;
            start24 = 1'b0;
            n = 0;
            while (fin24 !== 1'b1 && n < 40) begin
                @(posedge clk); #1; n++;
            end
            checks++;
            if (n != 13) begin
                failures++;
                $display("FAIL wide%0d latency got=%0d want=13", i, n);
            end
            checks++;
            if (result24 !== exp_r || ovf24 !== eo) begin
                failures++;
                $display("FAIL wide%0d result got=%h/%b want=%h/%b", i, result24, ovf24, exp_r, eo);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_hold_start();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
